alu_pipe_handshake: RTL and testbench

- Parametrised N-bit successor to the 1-bit ALU slice.
- Uses the same 3-bit command encoding and adds registered status flags (zero, carryout, overflow).
- Two-stage pipeline with valid/ready handshakes on input and output, plus a pass-through tag for in-order result matching.
- Sits between operand fetch and writeback in the lab CPU datapath. It may stall under downstream backpressure.

---
 rtl/alu_pipe_handshake.sv | 114 +++++++++++
 tb/tb_alu_pipe_handshake.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_handshake.sv
// Two-stage pipelined N-bit ALU with valid/ready handshakes on both ports.
// S1 holds the accepted operation, S2 holds the computed result and status flags.
module alu_pipe_handshake #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_command,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic                 out_carryout,
    output logic                 out_overflow,
    output logic                 out_zero,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_SLT  = 3'd3;
    localparam logic [2:0] CMD_AND  = 3'd4;
    localparam logic [2:0] CMD_NAND = 3'd5;
    localparam logic [2:0] CMD_NOR  = 3'd6;

    logic                 s1_valid;
    logic [2:0]           s1_command;
    logic [WIDTH-1:0]     s1_a;
    logic [WIDTH-1:0]     s1_b;
    logic [TAG_WIDTH-1:0] s1_tag;

    logic                 s2_advance;
    logic                 subtract;
    logic [WIDTH-1:0]     eff_b;
    logic [WIDTH:0]       sum;
    logic                 add_ovf;
    logic [WIDTH-1:0]     alu_result;
    logic                 alu_carry;
    logic                 alu_ovf;

    // Handshake: a transfer happens on a port at a rising edge where valid && ready.
    // Producers hold valid and payload until accepted; ready never depends on in_*.
    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;

    always_comb begin
        subtract   = (s1_command == CMD_SUB) || (s1_command == CMD_SLT);
        eff_b      = subtract ? ~s1_b : s1_b;
        sum        = {1'b0, s1_a} + {1'b0, eff_b} + {{WIDTH{1'b0}}, subtract};
        add_ovf    = (s1_a[WIDTH-1] == eff_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        case (s1_command)
            CMD_ADD, CMD_SUB: begin
                alu_result = sum[WIDTH-1:0];
                alu_carry  = sum[WIDTH];
                alu_ovf    = add_ovf;
            end
            // Signed less-than: sign of a-b corrected by overflow.
            CMD_SLT:  alu_result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            CMD_XOR:  alu_result = s1_a ^ s1_b;
            CMD_AND:  alu_result = s1_a & s1_b;
            CMD_NAND: alu_result = ~(s1_a & s1_b);
            CMD_NOR:  alu_result = ~(s1_a | s1_b);
            default:  alu_result = s1_a | s1_b;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_command <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_tag     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_command <= in_command;
                s1_a       <= in_a;
                s1_b       <= in_b;
                s1_tag     <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_carryout <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            out_tag      <= '0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result   <= alu_result;
                out_carryout <= alu_carry;
                out_overflow <= alu_ovf;
                out_zero     <= (alu_result == '0);
                out_tag      <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe_handshake.sv
// Directed bench for alu_pipe_handshake: hand-computed vectors feed an expected
// queue that an independent output monitor drains in order.
module tb_alu_pipe_handshake;

    localparam int WIDTH     = 32;
    localparam int TAG_WIDTH = 4;
    localparam int EW        = WIDTH + 3 + TAG_WIDTH;
    localparam int NV        = 14;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_command;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_result;
    logic                 out_carryout;
    logic                 out_overflow;
    logic                 out_zero;
    logic [TAG_WIDTH-1:0] out_tag;

    alu_pipe_handshake #(.WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_command   (in_command),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carryout (out_carryout),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_tag      (out_tag)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cycle = 0;
    initial forever begin
        @(posedge clk);
        cycle = cycle + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // vector table
    logic [2:0]           v_cmd [NV];
    logic [WIDTH-1:0]     v_a   [NV];
    logic [WIDTH-1:0]     v_b   [NV];
    logic [TAG_WIDTH-1:0] v_tag [NV];
    logic [WIDTH-1:0]     v_res [NV];
    logic                 v_c   [NV];
    logic                 v_o   [NV];
    logic                 v_z   [NV];

    task automatic set_vec(input int i, input logic [2:0] cmd, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [TAG_WIDTH-1:0] tag,
                           input logic [WIDTH-1:0] res, input logic c, input logic o,
                           input logic z);
        v_cmd[i] = cmd; v_a[i] = a; v_b[i] = b; v_tag[i] = tag;
        v_res[i] = res; v_c[i] = c; v_o[i] = o; v_z[i] = z;
    endtask

    // scoreboard
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic burst_mode = 1'b0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin : monitor
        logic [EW-1:0] exp_v;
        logic [EW-1:0] got_v;
        int last_pop;
        last_pop = 0;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                got_v = {out_result, out_carryout, out_overflow, out_zero, out_tag};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output actual=%h required=none", got_v);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (got_v !== exp_v) begin
                        n_fail++;
                        $display("FAIL result_tag%0d actual=%h required=%h",
                                 exp_v[TAG_WIDTH-1:0], got_v, exp_v);
                    end
                end
                if (burst_mode && out_tag != 1) begin
                    n_checks++;
                    if (cycle - last_pop != 1) begin
                        n_fail++;
                        $display("FAIL burst_gap tag%0d actual=%0d required=1", out_tag,
                                 cycle - last_pop);
                    end
                end
                last_pop = cycle;
            end
        end
    end

    // driver tasks
    task automatic present(input int idx);
        in_valid   = 1'b1;
        in_command = v_cmd[idx];
        in_a       = v_a[idx];
        in_b       = v_b[idx];
        in_tag     = v_tag[idx];
    endtask

    task automatic send_op(input int idx, output int waits);
        bit got;
        got   = 1'b0;
        waits = 0;
        present(idx);
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            else waits++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (got) exp_q.push_back({v_res[idx], v_c[idx], v_o[idx], v_z[idx], v_tag[idx]});
        else begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout tag%0d actual=not_accepted required=accepted", v_tag[idx]);
        end
    endtask

    initial begin : stimulus
        int w;
        set_vec(0,  3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 4'd3,  32'h0000_0000, 1'b1, 1'b0, 1'b1);
        set_vec(1,  3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd1,  32'h8000_0000, 1'b0, 1'b1, 1'b0);
        set_vec(2,  3'd1, 32'h0000_0005, 32'h0000_0007, 4'd2,  32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        set_vec(3,  3'd3, 32'h8000_0000, 32'h0000_0001, 4'd3,  32'h0000_0001, 1'b0, 1'b0, 1'b0);
        set_vec(4,  3'd3, 32'h7FFF_FFFF, 32'h8000_0000, 4'd4,  32'h0000_0000, 1'b0, 1'b0, 1'b1);
        set_vec(5,  3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5,  32'h0000_0000, 1'b0, 1'b0, 1'b1);
        set_vec(6,  3'd6, 32'h0000_0000, 32'h0000_0000, 4'd6,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        set_vec(7,  3'd2, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 4'd7,  32'hAAAA_AAAA, 1'b0, 1'b0, 1'b0);
        set_vec(8,  3'd4, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 4'd8,  32'h3030_3030, 1'b0, 1'b0, 1'b0);
        set_vec(9,  3'd7, 32'h1234_0000, 32'h0000_5678, 4'd9,  32'h1234_5678, 1'b0, 1'b0, 1'b0);
        set_vec(10, 3'd1, 32'h0000_0007, 32'h0000_0007, 4'd10, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        set_vec(11, 3'd1, 32'h8000_0000, 32'h0000_0001, 4'd11, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        set_vec(12, 3'd3, 32'h0000_0003, 32'h0000_0005, 4'd12, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        set_vec(13, 3'd3, 32'hFFFF_FFFF, 32'h0000_0000, 4'd13, 32'h0000_0001, 1'b0, 1'b0, 1'b0);

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_command = '0;
        in_a       = '0;
        in_b       = '0;
        in_tag     = '0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_result", out_result, 32'd0);
        check("reset_out_flags", {29'd0, out_carryout, out_overflow, out_zero}, 32'd0);
        check("reset_out_tag", {28'd0, out_tag}, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Op presented in cycle 0 must show on out_* in cycle 2.
        send_op(0, w);
        check("latency_not_yet", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        check("latency_tag", {28'd0, out_tag}, 32'd3);
        repeat (2) @(posedge clk);
        #1;

        burst_mode = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send_op(i, w);
            check($sformatf("burst_in_ready_tag%0d", i), w, 32'd0);
        end
        repeat (4) @(posedge clk);
        #1;
        burst_mode = 1'b0;

        out_ready = 1'b0;
        send_op(9, w);
        send_op(10, w);
        present(11);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_out_tag", {28'd0, out_tag}, 32'd9);
            check("stall_out_result", out_result, v_res[9]);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_op(11, w);
        send_op(12, w);
        send_op(13, w);
        repeat (4) @(posedge clk);
        #1;
        check("drain_after_stall", exp_q.size(), 32'd0);

        out_ready = 1'b0;
        send_op(6, w);
        send_op(1, w);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_reset_out_result", out_result, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("ready_after_async_reset", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("no_stale_after_reset", {31'd0, out_valid}, 32'd0);

        send_op(5, w);
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
